// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: ALU mode codes, sequencer op codes and state encodings shared by alu_seq
package alu_seq_pkg;
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic       SEQ_OP_MUL = 1'b0;
    localparam logic       SEQ_OP_DIV = 1'b1;
    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_e;
endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: IDLE/ITER/DONE sequencer with N-cycle iteration counter
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go_i,
    output logic accept_o,
    output logic iter_o,
    output logic done_o,
    output logic busy_o
);
    localparam int CW = $clog2(N) + 1;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;
    // next state: accept from IDLE, count N iterations, single DONE cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_o = state_q == ST_IDLE && go_i;
        iter_o   = state_q == ST_ITER;
        done_o   = state_q == ST_DONE;
        busy_o   = state_q != ST_IDLE;
        last     = iter_o && cnt_q == CW'(N - 1);
        if (accept_o) begin
            state_d = ST_ITER;
            cnt_d   = '0;
        end else if (iter_o) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = last ? ST_DONE : ST_ITER;
        end else if (done_o) begin
            state_d = ST_IDLE;
        end
    end
    // state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle shift-add multiplier over a shared ALU; restoring divider when ALU_SEQ_DIV_EN is defined
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] opa,
    input  logic [N-1:0] opb,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] res_hi,
    output logic [N-1:0] res_lo,
    output logic         div0,
    output logic         alu_own,
    output logic [3:0]   alu_mode,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic         alu_cin,
    input  logic [N-1:0] alu_out,
    input  logic         alu_cout
);
    logic         go, accept, iter, div_req, is_div;
    logic [N-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, dvsr;
    logic [N:0]   t;

    alu_seq_ctrl #(.N(N)) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .go_i     (go),
        .accept_o (accept),
        .iter_o   (iter),
        .done_o   (done),
        .busy_o   (busy)
    );

`ifdef ALU_SEQ_DIV_EN
    logic         is_div_q, div0_q;
    logic [N-1:0] dvsr_q;
    assign go      = start;
    assign div_req = op == SEQ_OP_DIV;
    assign is_div  = is_div_q;
    assign dvsr    = dvsr_q;
    assign div0    = div0_q;
    // division operand and divide-by-zero flag, captured on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q <= 1'b0;
            dvsr_q   <= '0;
            div0_q   <= 1'b0;
        end else if (accept) begin
            is_div_q <= div_req;
            dvsr_q   <= opb;
            div0_q   <= div_req && opb == '0;
        end
    end
`else
    assign go      = start && op == SEQ_OP_MUL;
    assign div_req = 1'b0;
    assign is_div  = 1'b0;
    assign dvsr    = '0;
    assign div0    = 1'b0;
`endif

    assign t        = {hi_q, lo_q[N-1]};
    assign alu_own  = iter;
    assign alu_cin  = 1'b0;
    assign alu_mode = iter && is_div ? ALU_SUB : ALU_ADD;
    assign alu_a    = iter ? (is_div ? t[N-1:0] : hi_q) : '0;
    assign alu_b    = iter ? (is_div ? dvsr : mcand_q) : '0;
    assign res_hi   = hi_q;
    assign res_lo   = lo_q;

    // hi/lo hold product or remainder/quotient; one shift step per ITER cycle
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (accept) begin
            hi_d = '0;
            lo_d = div_req ? opa : opb;
        end else if (iter) begin
            if (is_div)
                {hi_d, lo_d} = (t[N] || !alu_cout) ? {alu_out, lo_q[N-2:0], 1'b1}
                                                   : {t[N-1:0], lo_q[N-2:0], 1'b0};
            else
                {hi_d, lo_d} = lo_q[0] ? {alu_cout, alu_out, lo_q[N-1:1]}
                                       : {1'b0, hi_q, lo_q[N-1:1]};
        end
    end
    // datapath registers; reset clears results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (accept) mcand_q <= opa;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq with a behavioural ALU
module tb_alu_seq;
    import alu_seq_pkg::*;
    localparam int N = 8;
    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, op = 1'b0;
    logic [N-1:0] opa = '0, opb = '0;
    logic         busy, done, div0, alu_own, alu_cin, alu_cout;
    logic [N-1:0] res_hi, res_lo, alu_a, alu_b, alu_out;
    logic [3:0]   alu_mode;
    int           checks = 0, failures = 0;
    logic         sub_seen = 1'b0;

    always #5 clk = ~clk;

    alu_seq #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .div0(div0),
        .alu_own(alu_own), .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout)
    );

    // reference ALU: add with carry out, subtract with borrow out
    always_comb begin
        if (alu_mode == ALU_SUB) {alu_cout, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
        else                     {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin};
    end

    always @(posedge clk) if (alu_own && alu_mode == ALU_SUB) sub_seen <= 1'b1;

    // issue one op and watch until done (bounded); lat is 0 if done never came
    task automatic run_op(input logic o, input logic [N-1:0] a, input logic [N-1:0] b,
                          output int lat, output int own, output logic d0);
        @(posedge clk); #1;
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; own = 0; d0 = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (alu_own) own++;
            if (done) begin lat = k; d0 = div0; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0)    begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        if (res_hi !== 8'h00) begin failures++; $display("FAIL reset_hi got=%h exp=00", res_hi); end
        if (res_lo !== 8'h00) begin failures++; $display("FAIL reset_lo got=%h exp=00", res_lo); end
        if (div0 !== 1'b0)    begin failures++; $display("FAIL reset_div0 got=%b exp=0", div0); end
        if (alu_own !== 1'b0) begin failures++; $display("FAIL reset_own got=%b exp=0", alu_own); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_mul_basic();
        int lat, own; logic d0;
        run_op(SEQ_OP_MUL, 8'd13, 8'd11, lat, own, d0);
        checks += 4;
        if (lat !== 9)        begin failures++; $display("FAIL mul_latency got=%0d exp=9", lat); end
        if (own !== 8)        begin failures++; $display("FAIL mul_own_cycles got=%0d exp=8", own); end
        if (res_hi !== 8'h00) begin failures++; $display("FAIL mul13x11_hi got=%h exp=00", res_hi); end
        if (res_lo !== 8'h8F) begin failures++; $display("FAIL mul13x11_lo got=%h exp=8f", res_lo); end
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL mul_busy_after got=%b exp=0", busy); end
        if (res_lo !== 8'h8F) begin failures++; $display("FAIL mul_hold got=%h exp=8f", res_lo); end
    endtask

    task automatic test_mul_edges();
        int lat, own; logic d0;
        run_op(SEQ_OP_MUL, 8'd255, 8'd255, lat, own, d0);
        checks += 2;
        if (res_hi !== 8'hFE) begin failures++; $display("FAIL mul255_hi got=%h exp=fe", res_hi); end
        if (res_lo !== 8'h01) begin failures++; $display("FAIL mul255_lo got=%h exp=01", res_lo); end
        run_op(SEQ_OP_MUL, 8'd0, 8'd200, lat, own, d0);
        checks += 3;
        if (lat !== 9)        begin failures++; $display("FAIL mul0_latency got=%0d exp=9", lat); end
        if (res_hi !== 8'h00) begin failures++; $display("FAIL mul0_hi got=%h exp=00", res_hi); end
        if (res_lo !== 8'h00) begin failures++; $display("FAIL mul0_lo got=%h exp=00", res_lo); end
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        logic [N-1:0] hi = '1, lo = '1;
        @(posedge clk); #1;
        start = 1'b1; op = SEQ_OP_MUL; opa = 8'd13; opb = 8'd11;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (done) begin dones++; hi = res_hi; lo = res_lo; end
            start = (k == 3); opa = 8'd255; opb = 8'd255;
        end
        start = 1'b0;
        checks += 3;
        if (dones !== 1)  begin failures++; $display("FAIL busy_start_dones got=%0d exp=1", dones); end
        if (hi !== 8'h00) begin failures++; $display("FAIL busy_start_hi got=%h exp=00", hi); end
        if (lo !== 8'h8F) begin failures++; $display("FAIL busy_start_lo got=%h exp=8f", lo); end
    endtask

    task automatic test_reset_mid();
        int lat, own, dones = 0; logic d0;
        @(posedge clk); #1;
        start = 1'b1; op = SEQ_OP_MUL; opa = 8'd200; opb = 8'd200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0)    begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        if (alu_own !== 1'b0) begin failures++; $display("FAIL rstmid_own got=%b exp=0", alu_own); end
        if (res_hi !== 8'h00) begin failures++; $display("FAIL rstmid_hi got=%h exp=00", res_hi); end
        if (res_lo !== 8'h00) begin failures++; $display("FAIL rstmid_lo got=%h exp=00", res_lo); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dones++;
            if (k == 2) rst_n = 1'b1;
        end
        checks += 1;
        if (dones !== 0) begin failures++; $display("FAIL rstmid_done got=%0d exp=0", dones); end
        run_op(SEQ_OP_MUL, 8'd3, 8'd5, lat, own, d0);
        checks += 2;
        if (res_hi !== 8'h00) begin failures++; $display("FAIL mul3x5_hi got=%h exp=00", res_hi); end
        if (res_lo !== 8'h0F) begin failures++; $display("FAIL mul3x5_lo got=%h exp=0f", res_lo); end
    endtask

`ifdef ALU_SEQ_DIV_EN
    task automatic test_div();
        int lat, own; logic d0;
        run_op(SEQ_OP_DIV, 8'd200, 8'd7, lat, own, d0);
        checks += 4;
        if (lat !== 9)        begin failures++; $display("FAIL div_latency got=%0d exp=9", lat); end
        if (res_lo !== 8'h1C) begin failures++; $display("FAIL div200_q got=%h exp=1c", res_lo); end
        if (res_hi !== 8'h04) begin failures++; $display("FAIL div200_r got=%h exp=04", res_hi); end
        if (d0 !== 1'b0)      begin failures++; $display("FAIL div200_div0 got=%b exp=0", d0); end
        run_op(SEQ_OP_DIV, 8'd255, 8'd1, lat, own, d0);
        checks += 2;
        if (res_lo !== 8'hFF) begin failures++; $display("FAIL div255_q got=%h exp=ff", res_lo); end
        if (res_hi !== 8'h00) begin failures++; $display("FAIL div255_r got=%h exp=00", res_hi); end
        run_op(SEQ_OP_DIV, 8'h5A, 8'd0, lat, own, d0);
        checks += 3;
        if (res_lo !== 8'hFF) begin failures++; $display("FAIL div0_q got=%h exp=ff", res_lo); end
        if (res_hi !== 8'h5A) begin failures++; $display("FAIL div0_r got=%h exp=5a", res_hi); end
        if (d0 !== 1'b1)      begin failures++; $display("FAIL div0_flag got=%b exp=1", d0); end
        run_op(SEQ_OP_MUL, 8'd2, 8'd3, lat, own, d0);
        checks += 2;
        if (d0 !== 1'b0)      begin failures++; $display("FAIL div0_cleared got=%b exp=0", d0); end
        if (res_lo !== 8'h06) begin failures++; $display("FAIL mul2x3_lo got=%h exp=06", res_lo); end
    endtask
`else
    task automatic test_div_ignored();
        int hits = 0;
        @(posedge clk); #1;
        start = 1'b1; op = SEQ_OP_DIV; opa = 8'd200; opb = 8'd7;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy || alu_own || done) hits++;
        end
        start = 1'b0;
        checks += 2;
        if (hits !== 0)      begin failures++; $display("FAIL div_ignored_busy got=%0d exp=0", hits); end
        if (sub_seen !== 1'b0) begin failures++; $display("FAIL no_sub_driven got=%b exp=0", sub_seen); end
    endtask
`endif

    initial begin
        test_reset();
        test_mul_basic();
        test_mul_edges();
        test_start_while_busy();
        test_reset_mid();
`ifdef ALU_SEQ_DIV_EN
        test_div();
`else
        test_div_ignored();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle arithmetic sequencer sitting between the control unit and the shared combinational ALU. On a `start` request it takes ownership of the ALU and iterates it once per clock to produce an N×N→2N unsigned product (shift-and-add over `ALU_ADD`). With the division build option it also produces an unsigned quotient and remainder (restoring division over `ALU_SUB`). The top level muxes ALU inputs from this block whenever `alu_own` is high.

## Interface
- `N`, 8, operand width; must match the ALU's `N`.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = MUL, 1 = DIV (DIV only with `ALU_SEQ_DIV_EN`).
- `opa`  in  N  multiplicand / dividend; captured on accept.
- `opb`  in  N  multiplier / divisor; captured on accept.
- `busy`  out  1  high from accept until DONE is left.
- `done`  out  1  one-cycle completion pulse.
- `res_hi`  out  N  MUL: product[2N-1:N]; DIV: remainder.
- `res_lo`  out  N  MUL: product[N-1:0]; DIV: quotient.
- `div0`  out  1  divisor was zero; valid with `done`, held with results.
- `alu_own`  out  1  block drives the ALU this cycle.
- `alu_mode`  out  4  ALU mode code.
- `alu_a`, `alu_b`  out  N  ALU operands.
- `alu_cin`  out  1  ALU carry in; always 0.
- `alu_out`  in  N  ALU result, same-cycle combinational.
- `alu_cout`  in  1  ALU carry/borrow out.

## Operation
- States: IDLE, ITER, DONE. Iteration counter `cnt` is clog2(N)+1 bits.
- IDLE:
  - `start`=1 with a valid op loads operands, clears `cnt` and `div0`, and goes to ITER.
  - A valid op is MUL, or DIV only when division is built in.
  - MUL loads hi=0, lo=`opb`, mcand=`opa`.
  - DIV loads rem=0, quo=`opa`, dvsr=`opb`, and sets `div0`=(`opb`==0).
- ITER, MUL:
  - Drive `alu_mode`=`ALU_ADD`, `alu_a`=hi, `alu_b`=mcand.
  - If lo[0]=1: {hi,lo} ← {alu_cout, alu_out, lo[N-1:1]}.
  - Else: {hi,lo} ← {1'b0, hi, lo[N-1:1]}.
- ITER, DIV:
  - Shift: t = {rem, quo[N-1]}, N+1 bits.
  - Drive `alu_mode`=`ALU_SUB`, `alu_a`=t[N-1:0], `alu_b`=dvsr.
  - Accept the subtraction if t[N]=1 or `alu_cout`=0.
  - Accept: rem ← `alu_out`, quo ← {quo[N-2:0],1}.
  - Reject: rem ← t[N-1:0], quo ← {quo[N-2:0],0}.
- ITER exit: `cnt` increments each cycle; after N ITER cycles, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE. Results and `div0` hold until the next accept.
- Divide by zero needs no special path and yields quotient = all ones, remainder = dividend.
- `start` while busy is ignored and does not queue.
- Outputs outside ITER: `alu_own`=0, `alu_mode`=`ALU_ADD`, `alu_a`=`alu_b`=0.

## Timing
- Accept edge E0 starts the first ITER cycle. The last ITER cycle ends at edge E0+N.
- `done` is high between E0+N and E0+N+1, so MUL/DIV latency is N+1 cycles from accept.
- `busy` is high from E0 until E0+N+1.
- A new `start` can be accepted at edge E0+N+1. Back-to-back throughput is one op per N+1 cycles.
- `alu_own` is high exactly during the N ITER cycles.
- All ALU-facing outputs are registered-state decodes. The only combinational path is ALU → next-state, within one cycle.
- Reset values: state IDLE, `busy`=0, `done`=0, `res_hi`=`res_lo`=0, `div0`=0, `alu_own`=0.
- Reset asserted mid-operation aborts immediately. No `done` is produced and results are cleared.

## Configuration
- `ALU_SEQ_DIV_EN` defined:
  - DIV path, dvsr register and `div0` logic are built.
  - `op`=1 is accepted.
- `ALU_SEQ_DIV_EN` undefined:
  - `start` with `op`=1 is ignored and the block stays IDLE.
  - `div0` is tied 0.
  - No `ALU_SUB` is ever driven.

## Structure
- The shared parameters include supplies `ALU_ADD` and `ALU_SUB`.
- Add to it: op encodings `SEQ_OP_MUL`=0 and `SEQ_OP_DIV`=1, plus state encodings for IDLE, ITER and DONE.
- One natural sub-module: `alu_seq_ctrl`, the state machine plus `cnt`, emitting `iter`/`last`/`done`. Datapath registers stay in `alu_seq`.

## Test plan
- MUL 13×11, N=8 → `done` exactly 9 cycles after accept; `res_hi`=0x00, `res_lo`=0x8F; `alu_own` high for 8 cycles.
- MUL 255×255 → `res_hi`=0xFE, `res_lo`=0x01, exercising carry out of every add. MUL 0×200 → 0x0000.
- DIV 200÷7 (DIV_EN) → `res_lo`=0x1C, `res_hi`=0x04, `div0`=0. DIV 255÷1 → 0xFF rem 0.
- DIV 0x5A÷0 → `res_lo`=0xFF, `res_hi`=0x5A, `div0`=1 with `done`.
- `start` pulsed mid-ITER with new operands → ignored; first result unchanged; only one `done`.
- `rst_n` low at 4th ITER cycle → `busy`/`alu_own`/results 0 immediately, no `done`; the next MUL 3×5 gives 0x000F. Without DIV_EN, `op`=1 start → `busy` stays 0.
